// File: rtl/biquad_coeff_sequencer_pkg.sv
// ---- biquad_seq_pkg: shared types for the biquad coefficient sequencer (rev 1.0) ----
`default_nettype none

package biquad_seq_pkg;

  localparam int ADR_W  = 8;
  localparam int DAT_W  = 32;
  localparam int SEL_W  = 4;
  localparam int WORD_W = 5;
  localparam int TADR_W = WORD_W + 1;
  localparam int BYP_W  = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    REQ     = 3'd2,
    BACKOFF = 3'd3,
    NEXT    = 3'd4,
    UPDATE  = 3'd5,
    DONE    = 3'd6,
    FAIL    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    STAT_OK      = 3'd0,
    STAT_ERR     = 3'd1,
    STAT_TIMEOUT = 3'd2,
    STAT_RETRY   = 3'd3,
    STAT_ABORT   = 3'd4
  } status_t;

  function automatic logic [ADR_W-1:0] wb_word_addr(input logic stage, input logic [WORD_W-1:0] word);
    return {stage, word, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/biquad_coeff_sequencer_if.sv
// ---- biquad_coeff_sequencer_if: Wishbone master/slave bundle (rev 1.0) ----
`default_nettype none

interface biquad_coeff_sequencer_if;

  logic                                cyc;
  logic                                stb;
  logic                                we;
  logic [biquad_seq_pkg::ADR_W-1:0]    adr;
  logic [biquad_seq_pkg::DAT_W-1:0]    dat;
  logic [biquad_seq_pkg::SEL_W-1:0]    sel;
  logic                                ack;
  logic                                err;
  logic                                rty;

  modport master (
    output cyc, stb, we, adr, dat, sel,
    input  ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat, sel,
    output ack, err, rty
  );

endinterface

`default_nettype wire

// File: rtl/biquad_coeff_sequencer_table.sv
// ---- biquad_seq_table: 2*NCOEF x 32 staging RAM, 1-cycle read, writes locked while busy (rev 1.0) ----
`default_nettype none

module biquad_seq_table
  import biquad_seq_pkg::*;
#(
  parameter int NCOEF = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              lock,
  input  wire logic              wr_en,
  input  wire logic [TADR_W-1:0] wr_adr,
  input  wire logic [DAT_W-1:0]  wr_dat,
  input  wire logic [TADR_W-1:0] rd_adr,
  output logic      [DAT_W-1:0]  rd_dat
);

  localparam int DEPTH = 2 * NCOEF;
  localparam int IW    = $clog2(DEPTH);

  logic [DAT_W-1:0] mem [DEPTH];
  logic             wr_ok;

  // Stage 1 words sit directly after the NCOEF stage 0 words.
  function automatic logic [IW-1:0] phys(input logic [TADR_W-1:0] a);
    return a[WORD_W] ? (IW'(NCOEF) + IW'(a[WORD_W-1:0])) : IW'(a[WORD_W-1:0]);
  endfunction

  assign wr_ok = wr_en && !lock && ({27'd0, wr_adr[WORD_W-1:0]} < 32'(NCOEF));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[phys(wr_adr)] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_dat <= '0;
    end else begin
      rd_dat <= mem[phys(rd_adr)];
    end
  end

endmodule

`default_nettype wire

// File: rtl/biquad_coeff_sequencer.sv
// ---- biquad_coeff_sequencer: Wishbone master bulk-loading the two-stage biquad chain (rev 1.0) ----
`default_nettype none

module biquad_coeff_sequencer
  import biquad_seq_pkg::*;
#(
  parameter int NCOEF     = 16,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  wire logic              wb_clk_i,
  input  wire logic              wb_rst_n_i,
  input  wire logic              tbl_we_i,
  input  wire logic [TADR_W-1:0] tbl_adr_i,
  input  wire logic [DAT_W-1:0]  tbl_dat_i,
  input  wire logic [BYP_W-1:0]  byp0_i,
  input  wire logic [BYP_W-1:0]  byp1_i,
  input  wire logic              start_i,
  input  wire logic [1:0]        stage_en_i,
  input  wire logic              abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic      [2:0]        status_o,
  biquad_coeff_sequencer_if.master m,
  output logic                   notch_update_o,
  output logic      [BYP_W-1:0]  notch0_byp_o,
  output logic      [BYP_W-1:0]  notch1_byp_o
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t              state;
  status_t             status_q;
  status_t             fault_code;
  logic                fault;
  logic [1:0]          en_q;
  logic [BYP_W-1:0]    byp0_q;
  logic [BYP_W-1:0]    byp1_q;
  logic                stg;
  logic [WORD_W-1:0]   idx;
  logic                fin;
  logic                word_last;
  logic [RW-1:0]       rty_cnt;
  logic [TW-1:0]       tmo_cnt;
  logic                cyc_q;
  logic                busy_q;
  logic                done_q;
  logic                upd_q;
  logic [BYP_W-1:0]    nbyp0_q;
  logic [BYP_W-1:0]    nbyp1_q;
  logic [DAT_W-1:0]    rd_dat;

  biquad_seq_table #(
    .NCOEF (NCOEF)
  ) u_table (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n_i),
    .lock   (busy_q),
    .wr_en  (tbl_we_i),
    .wr_adr (tbl_adr_i),
    .wr_dat (tbl_dat_i),
    .rd_adr ({stg, idx}),
    .rd_dat (rd_dat)
  );

  assign word_last = (idx == WORD_W'(NCOEF - 1));

  // Abort outranks every bus response; err outranks rty, rty outranks ack.
  always_comb begin
    fault      = 1'b0;
    fault_code = STAT_OK;
    if (abort_i && (state inside {LOAD, REQ, BACKOFF, NEXT})) begin
      fault      = 1'b1;
      fault_code = STAT_ABORT;
    end else if (state == REQ) begin
      if (m.err) begin
        fault      = 1'b1;
        fault_code = STAT_ERR;
      end else if (m.rty && (rty_cnt == RW'(MAX_RETRY))) begin
        fault      = 1'b1;
        fault_code = STAT_RETRY;
      end else if (!m.rty && !m.ack && (tmo_cnt == TW'(TIMEOUT - 1))) begin
        fault      = 1'b1;
        fault_code = STAT_TIMEOUT;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state    <= IDLE;
      status_q <= STAT_OK;
      en_q     <= '0;
      byp0_q   <= '0;
      byp1_q   <= '0;
      stg      <= 1'b0;
      idx      <= '0;
      fin      <= 1'b0;
      rty_cnt  <= '0;
      tmo_cnt  <= '0;
      cyc_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      upd_q    <= 1'b0;
      nbyp0_q  <= '0;
      nbyp1_q  <= '0;
    end else begin
      done_q <= 1'b0;
      upd_q  <= 1'b0;
      if (fault) begin
        state    <= FAIL;
        status_q <= fault_code;
        cyc_q    <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_i) begin
              status_q <= STAT_OK;
              if (stage_en_i != 2'b00) begin
                en_q    <= stage_en_i;
                byp0_q  <= byp0_i;
                byp1_q  <= byp1_i;
                stg     <= ~stage_en_i[0];
                idx     <= '0;
                fin     <= 1'b0;
                rty_cnt <= '0;
                busy_q  <= 1'b1;
                state   <= LOAD;
              end else begin
                done_q <= 1'b1;
                state  <= DONE;
              end
            end
          end
          LOAD, BACKOFF: begin
            cyc_q   <= 1'b1;
            tmo_cnt <= '0;
            state   <= REQ;
          end
          REQ: begin
            if (m.rty) begin
              rty_cnt <= rty_cnt + 1'b1;
              cyc_q   <= 1'b0;
              state   <= BACKOFF;
            end else if (m.ack) begin
              cyc_q   <= 1'b0;
              rty_cnt <= '0;
              state   <= NEXT;
              // Advance here so NEXT can present the following table read.
              if (word_last) begin
                idx <= '0;
                if (!stg && en_q[1]) begin
                  stg <= 1'b1;
                end else begin
                  fin <= 1'b1;
                end
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          NEXT: begin
            if (fin) begin
              upd_q   <= 1'b1;
              nbyp0_q <= byp0_q;
              nbyp1_q <= byp1_q;
              state   <= UPDATE;
            end else begin
              cyc_q   <= 1'b1;
              tmo_cnt <= '0;
              state   <= REQ;
            end
          end
          UPDATE: begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
          DONE, FAIL: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign m.cyc          = cyc_q;
  assign m.stb          = cyc_q;
  assign m.we           = cyc_q;
  assign m.adr          = wb_word_addr(stg, idx);
  assign m.dat          = rd_dat;
  assign m.sel          = 4'hF;

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign status_o       = status_q;
  assign notch_update_o = upd_q;
  assign notch0_byp_o   = nbyp0_q;
  assign notch1_byp_o   = nbyp1_q;

endmodule

`default_nettype wire
